pulse_width_scheduler: RTL and testbench

Controller that drives a single-bit strobe `sig` whose high time must stay within [MIN_HIGH, MAX_HIGH] cycles and whose low gap must be at least MIN_LOW cycles.
Requesters submit a desired pulse length through a valid/ready handshake. The block clamps the length into the legal window, sequences the pulse, and reports completion and clamping.
It is the sole legal driver of `sig`, so the pulse-duration assertions on `sig` hold by construction.

---
 rtl/pws_pkg.sv | 7 +
 rtl/pws_len_clamp.sv | 20 ++
 rtl/pulse_width_scheduler.sv | 80 ++++++++
 tb/tb_pulse_width_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pws_pkg.sv
// pws_pkg: shared state encoding and default pulse timing limits
package pws_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;
  localparam int DEF_MIN_HIGH = 2;
  localparam int DEF_MAX_HIGH = 6;
  localparam int DEF_MIN_LOW = 1;
endpackage

// File: rtl/pws_len_clamp.sv
// pws_len_clamp: clamps a requested pulse length into [MIN_HIGH, MAX_HIGH]
module pws_len_clamp
  import pws_pkg::*;
#(
  parameter int MIN_HIGH = DEF_MIN_HIGH,
  parameter int MAX_HIGH = DEF_MAX_HIGH,
  parameter int LEN_W = 4
) (
  input  logic [LEN_W-1:0] len,
  output logic [LEN_W-1:0] target,
  output logic             oor
);
  logic lo, hi;
  always_comb begin
    lo = len < LEN_W'(MIN_HIGH);
    hi = len > LEN_W'(MAX_HIGH);
    oor = lo | hi;
    target = lo ? LEN_W'(MIN_HIGH) : hi ? LEN_W'(MAX_HIGH) : len;
  end
endmodule

// File: rtl/pulse_width_scheduler.sv
// pulse_width_scheduler: sequences a strobe whose high and low runs stay within fixed bounds
module pulse_width_scheduler
  import pws_pkg::*;
#(
  parameter int MIN_HIGH = DEF_MIN_HIGH,
  parameter int MAX_HIGH = DEF_MAX_HIGH,
  parameter int MIN_LOW = DEF_MIN_LOW,
  parameter int LEN_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [LEN_W-1:0] req_len,
  input  logic             abort,
  output logic             sig,
  output logic             busy,
  output logic             done,
  output logic             clamp_err,
  output logic [CNT_W-1:0] pulse_cnt
);
  localparam int GW = $clog2(MIN_LOW + 1);
  if (MIN_HIGH < 1 || MAX_HIGH < MIN_HIGH || MIN_LOW < 1 || (2 ** LEN_W) <= MAX_HIGH) begin : g_bad_params
    $error("pulse_width_scheduler: illegal timing parameters");
  end
  state_t state, state_n;
  logic [LEN_W-1:0] hcnt, target, tgt_c, hi_run;
  logic [GW-1:0] gcnt, lo_run;
  logic abort_l, oor, accept, hi_end, gap_last;
  pws_len_clamp #(.MIN_HIGH(MIN_HIGH), .MAX_HIGH(MAX_HIGH), .LEN_W(LEN_W)) u_clamp (
    .len(req_len),
    .target(tgt_c),
    .oor(oor)
  );
  always_comb begin
    gap_last = state == GAP && gcnt == GW'(MIN_LOW);
    req_ready = state == IDLE || gap_last;
    accept = req_valid && req_ready;
    hi_end = state == HIGH && (hcnt == target || ((abort || abort_l) && hcnt >= LEN_W'(MIN_HIGH)));
    state_n = accept ? HIGH : hi_end ? GAP : req_ready ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sig <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      clamp_err <= 1'b0;
      pulse_cnt <= '0;
      abort_l <= 1'b0;
      hcnt <= '0;
      gcnt <= '0;
      target <= '0;
    end else begin
      state <= state_n;
      sig <= state_n == HIGH;
      busy <= state_n != IDLE;
      done <= hi_end;
      clamp_err <= accept && oor;
      pulse_cnt <= pulse_cnt + CNT_W'(hi_end);
      abort_l <= state == HIGH && !hi_end && (abort_l || abort);
      hcnt <= accept ? LEN_W'(1) : hcnt + LEN_W'(state == HIGH);
      gcnt <= hi_end ? GW'(1) : (state == GAP && !gap_last) ? gcnt + GW'(1) : gcnt;
      if (accept) target <= tgt_c;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_run <= '0;
      lo_run <= GW'(MIN_LOW);
    end else begin
      hi_run <= sig ? hi_run + LEN_W'(1) : '0;
      lo_run <= sig ? '0 : (lo_run == GW'(MIN_LOW)) ? lo_run : lo_run + GW'(1);
    end
  end
  a_high_max: assert property (@(posedge clk) disable iff (rst) sig |-> hi_run < LEN_W'(MAX_HIGH));
  a_high_min: assert property (@(posedge clk) disable iff (rst) $fell(sig) && !$past(rst) |-> hi_run >= LEN_W'(MIN_HIGH));
  a_low_min: assert property (@(posedge clk) disable iff (rst) $rose(sig) |-> lo_run == GW'(MIN_LOW));
endmodule

// File: tb/tb_pulse_width_scheduler.sv
// tb_pulse_width_scheduler: directed checks of pulse length, clamping, abort, back-to-back and reset
module tb_pulse_width_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [3:0] req_len = '0;
  logic abort = 1'b0;
  logic sig, busy, done, clamp_err;
  logic [15:0] pulse_cnt;
  logic [15:0] exp_cnt = '0;
  int n_cmp = 0;
  int n_bad = 0;
  pulse_width_scheduler dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_len(req_len),
    .abort(abort),
    .sig(sig),
    .busy(busy),
    .done(done),
    .clamp_err(clamp_err),
    .pulse_cnt(pulse_cnt)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [3:0] len);
    int w;
    w = 0;
    while (req_ready !== 1'b1 && w < 20) begin
      cyc();
      w++;
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL send_ready: req_ready=%b after %0d cycles, required 1", req_ready, w);
    end
    req_valid = 1'b1;
    req_len = len;
    cyc();
    req_valid = 1'b0;
  endtask
  task automatic measure(input int ab_at, output int hi, output logic ce, output logic ce_late, output logic dn);
    hi = 0;
    ce = clamp_err;
    ce_late = 1'b0;
    while (sig === 1'b1 && hi < 20) begin
      hi++;
      if (hi > 1) ce_late = ce_late | clamp_err;
      abort = (hi == ab_at);
      cyc();
      abort = 1'b0;
    end
    dn = done;
  endtask
  task automatic test_reset();
    n_cmp += 6;
    if (sig !== 1'b0) begin n_bad++; $display("FAIL reset_sig: got %b required 0", sig); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b required 0", done); end
    if (clamp_err !== 1'b0) begin n_bad++; $display("FAIL reset_clamp_err: got %b required 0", clamp_err); end
    if (pulse_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_pulse_cnt: got %0d required 0", pulse_cnt); end
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
  endtask
  task automatic test_basic();
    int hi;
    logic ce, cl, dn;
    send(4'd2);
    measure(0, hi, ce, cl, dn);
    exp_cnt++;
    n_cmp += 7;
    if (hi !== 2) begin n_bad++; $display("FAIL basic_high: got %0d cycles required 2", hi); end
    if (ce !== 1'b0 || cl !== 1'b0) begin n_bad++; $display("FAIL basic_clamp_err: got %b/%b required 0/0", ce, cl); end
    if (dn !== 1'b1) begin n_bad++; $display("FAIL basic_done: got %b required 1", dn); end
    if (pulse_cnt !== exp_cnt) begin n_bad++; $display("FAIL basic_cnt: got %0d required %0d", pulse_cnt, exp_cnt); end
    if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_gap_busy: got %b required 1", busy); end
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL basic_gap_ready: got %b required 1", req_ready); end
    cyc();
    if (done !== 1'b0 || busy !== 1'b0 || sig !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_idle: done=%b busy=%b sig=%b required 0/0/0", done, busy, sig);
    end
  endtask
  task automatic test_clamp();
    logic [3:0] lens[4] = '{4'd6, 4'd7, 4'd1, 4'd0};
    int exp_hi[4] = '{6, 6, 2, 2};
    logic exp_ce[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    int hi;
    logic ce, cl, dn;
    for (int i = 0; i < 4; i++) begin
      send(lens[i]);
      measure(0, hi, ce, cl, dn);
      exp_cnt++;
      n_cmp += 5;
      if (hi !== exp_hi[i]) begin n_bad++; $display("FAIL clamp_high len=%0d: got %0d required %0d", lens[i], hi, exp_hi[i]); end
      if (ce !== exp_ce[i]) begin n_bad++; $display("FAIL clamp_err len=%0d: got %b required %b", lens[i], ce, exp_ce[i]); end
      if (cl !== 1'b0) begin n_bad++; $display("FAIL clamp_err_width len=%0d: got late %b required 0", lens[i], cl); end
      if (dn !== 1'b1) begin n_bad++; $display("FAIL clamp_done len=%0d: got %b required 1", lens[i], dn); end
      if (pulse_cnt !== exp_cnt) begin n_bad++; $display("FAIL clamp_cnt len=%0d: got %0d required %0d", lens[i], pulse_cnt, exp_cnt); end
    end
    cyc();
    cyc();
  endtask
  task automatic test_back_to_back();
    logic [11:0] sv, rv, esv, erv;
    for (int i = 0; i < 12; i++) begin
      esv[i] = (i % 4) != 3;
      erv[i] = (i % 4) == 3;
    end
    req_len = 4'd3;
    req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      sv[i] = sig;
      rv[i] = req_ready;
    end
    req_valid = 1'b0;
    exp_cnt += 3;
    n_cmp += 3;
    if (sv !== esv) begin n_bad++; $display("FAIL b2b_sig: got %b required %b", sv, esv); end
    if (rv !== erv) begin n_bad++; $display("FAIL b2b_ready: got %b required %b", rv, erv); end
    if (pulse_cnt !== exp_cnt) begin n_bad++; $display("FAIL b2b_cnt: got %0d required %0d", pulse_cnt, exp_cnt); end
    cyc();
    cyc();
  endtask
  task automatic test_abort();
    int ab[3] = '{1, 2, 4};
    int exp_hi[3] = '{2, 2, 4};
    int hi;
    logic ce, cl, dn;
    for (int i = 0; i < 3; i++) begin
      send(4'd6);
      measure(ab[i], hi, ce, cl, dn);
      exp_cnt++;
      n_cmp += 3;
      if (hi !== exp_hi[i]) begin n_bad++; $display("FAIL abort_high at=%0d: got %0d required %0d", ab[i], hi, exp_hi[i]); end
      if (dn !== 1'b1) begin n_bad++; $display("FAIL abort_done at=%0d: got %b required 1", ab[i], dn); end
      if (pulse_cnt !== exp_cnt) begin n_bad++; $display("FAIL abort_cnt at=%0d: got %0d required %0d", ab[i], pulse_cnt, exp_cnt); end
    end
    cyc();
    cyc();
    abort = 1'b1;
    cyc();
    cyc();
    n_cmp++;
    if (sig !== 1'b0 || busy !== 1'b0 || pulse_cnt !== exp_cnt) begin
      n_bad++;
      $display("FAIL abort_idle: sig=%b busy=%b cnt=%0d required 0/0/%0d", sig, busy, pulse_cnt, exp_cnt);
    end
    abort = 1'b0;
    send(4'd3);
    measure(0, hi, ce, cl, dn);
    exp_cnt++;
    n_cmp += 2;
    if (hi !== 3) begin n_bad++; $display("FAIL abort_idle_after: got %0d cycles required 3", hi); end
    if (pulse_cnt !== exp_cnt) begin n_bad++; $display("FAIL abort_idle_cnt: got %0d required %0d", pulse_cnt, exp_cnt); end
    cyc();
    cyc();
  endtask
  task automatic test_reset_mid();
    int hi;
    logic ce, cl, dn;
    send(4'd6);
    cyc();
    cyc();
    n_cmp++;
    if (sig !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_sig: got %b required 1", sig); end
    rst = 1'b1;
    req_valid = 1'b1;
    req_len = 4'd4;
    cyc();
    exp_cnt = '0;
    n_cmp += 4;
    if (sig !== 1'b0) begin n_bad++; $display("FAIL rstmid_sig: got %b required 0", sig); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done: got %b required 0", done); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b required 0", busy); end
    if (pulse_cnt !== 16'd0) begin n_bad++; $display("FAIL rstmid_cnt: got %0d required 0", pulse_cnt); end
    rst = 1'b0;
    cyc();
    req_valid = 1'b0;
    measure(0, hi, ce, cl, dn);
    exp_cnt++;
    n_cmp += 3;
    if (hi !== 4) begin n_bad++; $display("FAIL rstmid_after_high: got %0d required 4", hi); end
    if (dn !== 1'b1) begin n_bad++; $display("FAIL rstmid_after_done: got %b required 1", dn); end
    if (pulse_cnt !== exp_cnt) begin n_bad++; $display("FAIL rstmid_after_cnt: got %0d required %0d", pulse_cnt, exp_cnt); end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
  initial begin
    #10 rst = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_clamp();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
